// File: rtl/fp_wb_arbiter.sv
// FP register-file writeback front end: two per-source FIFOs, round-robin arbitration, and a registered write port.
// Optional FP_WB_BUSY_EN adds busy_mask, a per-register pending-write map.
module fp_wb_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  wr_En,
    output logic [ADDR_WIDTH-1:0] wr_Addr,
    output logic [DATA_WIDTH-1:0] wr_Data,
    output logic                  idle
`ifdef FP_WB_BUSY_EN
    ,
    output logic [2**ADDR_WIDTH-1:0] busy_mask
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    // Records which source won the most recent grant; the other one wins the next tie.
    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    entry_t mem_a [FIFO_DEPTH];
    entry_t mem_b [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_a_q, wr_ptr_a_d, rd_ptr_a_q, rd_ptr_a_d;
    logic [PTR_W-1:0]      wr_ptr_b_q, wr_ptr_b_d, rd_ptr_b_q, rd_ptr_b_d;
    logic [CNT_W-1:0]      count_a_q, count_a_d, count_b_q, count_b_d;
    src_e                  last_q, last_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic   push_a, push_b, grant_a, grant_b, ne_a, ne_b;
    entry_t head_a, head_b;

    // Ready looks only at the count, so a full FIFO refuses a push even while it is being popped.
    assign a_ready = count_a_q < FULL_CNT;
    assign b_ready = count_b_q < FULL_CNT;

    assign wr_En   = wr_en_q;
    assign wr_Addr = wr_addr_q;
    assign wr_Data = wr_data_q;
    assign idle    = (count_a_q == '0) && (count_b_q == '0) && !wr_en_q;

    // NOTE: combinational logic uses blocking '='; sequential state below uses non-blocking '<='.
    always_comb begin
        // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        ne_a    = count_a_q != '0;
        ne_b    = count_b_q != '0;
        push_a  = a_valid && a_ready;
        push_b  = b_valid && b_ready;
        grant_a = ne_a && (!ne_b || last_q == SRC_B);
        grant_b = ne_b && (!ne_a || last_q == SRC_A);
        head_a  = mem_a[rd_ptr_a_q];
        head_b  = mem_b[rd_ptr_b_q];

        wr_ptr_a_d = push_a  ? wr_ptr_a_q + PTR_W'(1) : wr_ptr_a_q;
        wr_ptr_b_d = push_b  ? wr_ptr_b_q + PTR_W'(1) : wr_ptr_b_q;
        rd_ptr_a_d = grant_a ? rd_ptr_a_q + PTR_W'(1) : rd_ptr_a_q;
        rd_ptr_b_d = grant_b ? rd_ptr_b_q + PTR_W'(1) : rd_ptr_b_q;
        count_a_d  = count_a_q + CNT_W'(push_a) - CNT_W'(grant_a);
        count_b_d  = count_b_q + CNT_W'(push_b) - CNT_W'(grant_b);

        last_d  = grant_a ? SRC_A : (grant_b ? SRC_B : last_q);
        wr_en_d = grant_a || grant_b;
        if (grant_a) begin
            wr_addr_d = head_a.addr;
            wr_data_d = head_a.data;
        end else if (grant_b) begin
            wr_addr_d = head_b.addr;
            wr_data_d = head_b.data;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_a_q <= '0;
            rd_ptr_a_q <= '0;
            count_a_q  <= '0;
            wr_ptr_b_q <= '0;
            rd_ptr_b_q <= '0;
            count_b_q  <= '0;
            last_q     <= SRC_B;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_ptr_a_q <= wr_ptr_a_d;
            rd_ptr_a_q <= rd_ptr_a_d;
            count_a_q  <= count_a_d;
            wr_ptr_b_q <= wr_ptr_b_d;
            rd_ptr_b_q <= rd_ptr_b_d;
            count_b_q  <= count_b_d;
            last_q     <= last_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // NOTE: FIFO storage has no reset; the counts alone decide which slots hold live data.
    always_ff @(posedge Clk) begin
        if (push_a) mem_a[wr_ptr_a_q] <= {a_addr, a_data};
        if (push_b) mem_b[wr_ptr_b_q] <= {b_addr, b_data};
    end

`ifdef FP_WB_BUSY_EN
    // A slot is live when its distance from the read pointer (modulo depth) is below the count.
    function automatic logic slot_live(input logic [PTR_W-1:0] idx,
                                       input logic [PTR_W-1:0] rd,
                                       input logic [CNT_W-1:0] cnt);
        logic [PTR_W-1:0] off;
        off = idx - rd;
        return {1'b0, off} < cnt;
    endfunction

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (slot_live(PTR_W'(i), rd_ptr_a_q, count_a_q)) busy_mask[mem_a[i].addr] = 1'b1;
            if (slot_live(PTR_W'(i), rd_ptr_b_q, count_b_q)) busy_mask[mem_b[i].addr] = 1'b1;
        end
        if (wr_en_q) busy_mask[wr_addr_q] = 1'b1;
    end
`endif

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed testbench for fp_wb_arbiter: reset, latency, contention, backpressure, full FIFO, async reset, busy map.
module tb_fp_wb_arbiter;

    logic        Clk;
    logic        Rst;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [4:0]  a_addr, b_addr;
    logic [63:0] a_data, b_data;
    logic        wr_En;
    logic [4:0]  wr_Addr;
    logic [63:0] wr_Data;
    logic        idle;
`ifdef FP_WB_BUSY_EN
    logic [31:0] busy_mask;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [4:0]  stim_a_addr[$], stim_b_addr[$];
    logic [63:0] stim_a_data[$], stim_b_data[$];
    logic [4:0]  got_addr[$];
    logic [63:0] got_data[$];
    int          got_cyc[$];
    bit          rdy_a_hist[0:511];
    bit          rdy_b_hist[0:511];
    bit          timed_out;

    localparam logic [63:0] A_TAG = 64'hA000_0000_0000_0000;
    localparam logic [63:0] B_TAG = 64'hB000_0000_0000_0000;

    fp_wb_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .FIFO_DEPTH(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .wr_En(wr_En), .wr_Addr(wr_Addr), .wr_Data(wr_Data), .idle(idle)
`ifdef FP_WB_BUSY_EN
        , .busy_mask(busy_mask)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // Leaves the bench 1 time unit after edge 0 with reset released.
    task automatic do_reset();
        a_valid = 1'b0; b_valid = 1'b0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
    endtask

    // Drives both stimulus queues with valid/ready; collects every write and the ready flags seen after each edge.
    task automatic run_streams();
        int ia, ib, cyc;
        bit fa, fb;
        ia = 0; ib = 0; cyc = 0; timed_out = 1'b0;
        got_addr.delete(); got_data.delete(); got_cyc.delete();
        forever begin
            a_valid = (ia < stim_a_addr.size());
            b_valid = (ib < stim_b_addr.size());
            if (a_valid) begin a_addr = stim_a_addr[ia]; a_data = stim_a_data[ia]; end
            if (b_valid) begin b_addr = stim_b_addr[ib]; b_data = stim_b_data[ib]; end
            if (!a_valid && !b_valid && idle) break;
            if (cyc >= 300) begin timed_out = 1'b1; break; end
            fa = a_valid && a_ready;
            fb = b_valid && b_ready;
            @(posedge Clk); #1;
            cyc++;
            if (fa) ia++;
            if (fb) ib++;
            rdy_a_hist[cyc] = a_ready;
            rdy_b_hist[cyc] = b_ready;
            if (wr_En) begin
                got_addr.push_back(wr_Addr);
                got_data.push_back(wr_Data);
                got_cyc.push_back(cyc);
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic load_streams(input int na, input int a_base, input int nb, input int b_base);
        stim_a_addr.delete(); stim_a_data.delete(); stim_b_addr.delete(); stim_b_data.delete();
        for (int i = 0; i < na; i++) begin
            stim_a_addr.push_back(5'(a_base + i));
            stim_a_data.push_back(A_TAG | 64'(i));
        end
        for (int i = 0; i < nb; i++) begin
            stim_b_addr.push_back(5'(b_base + i));
            stim_b_data.push_back(B_TAG | 64'(i));
        end
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (wr_En !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", wr_En); else pass_cnt++;
        total_cnt++; if (wr_Addr !== 5'd0) $display("FAIL reset_wr_addr: got %0d want 0", wr_Addr); else pass_cnt++;
        total_cnt++; if (wr_Data !== 64'd0) $display("FAIL reset_wr_data: got %h want 0", wr_Data); else pass_cnt++;
        total_cnt++; if (idle !== 1'b1) $display("FAIL reset_idle: got %b want 1", idle); else pass_cnt++;
        total_cnt++; if (a_ready !== 1'b1) $display("FAIL reset_a_ready: got %b want 1", a_ready); else pass_cnt++;
        total_cnt++; if (b_ready !== 1'b1) $display("FAIL reset_b_ready: got %b want 1", b_ready); else pass_cnt++;
`ifdef FP_WB_BUSY_EN
        total_cnt++; if (busy_mask !== 32'd0) $display("FAIL reset_busy: got %h want 0", busy_mask); else pass_cnt++;
`endif
    endtask

    task automatic test_single_latency();
        do_reset();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 64'h4000_0000_0000_0000;
        @(posedge Clk); #1;  // edge 1: accepted
        a_valid = 1'b0;
        total_cnt++; if (wr_En !== 1'b0) $display("FAIL lat_e1_wr_en: got %b want 0", wr_En); else pass_cnt++;
        total_cnt++; if (idle !== 1'b0) $display("FAIL lat_e1_idle: got %b want 0", idle); else pass_cnt++;
        @(posedge Clk); #1;  // edge 2: granted
        total_cnt++; if (wr_En !== 1'b1) $display("FAIL lat_e2_wr_en: got %b want 1", wr_En); else pass_cnt++;
        total_cnt++; if (wr_Addr !== 5'd3) $display("FAIL lat_e2_addr: got %0d want 3", wr_Addr); else pass_cnt++;
        total_cnt++; if (wr_Data !== 64'h4000_0000_0000_0000) $display("FAIL lat_e2_data: got %h want 4000000000000000", wr_Data); else pass_cnt++;
        total_cnt++; if (idle !== 1'b0) $display("FAIL lat_e2_idle: got %b want 0", idle); else pass_cnt++;
        @(posedge Clk); #1;  // edge 3: pulse over
        total_cnt++; if (wr_En !== 1'b0) $display("FAIL lat_e3_wr_en: got %b want 0", wr_En); else pass_cnt++;
        total_cnt++; if (idle !== 1'b1) $display("FAIL lat_e3_idle: got %b want 1", idle); else pass_cnt++;
        total_cnt++; if (wr_Addr !== 5'd3) $display("FAIL lat_e3_addr_hold: got %0d want 3", wr_Addr); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int exp_addr[16] = '{0, 8, 1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 6, 14, 7, 15};
        logic [63:0] ed;
        do_reset();
        load_streams(8, 0, 8, 8);
        run_streams();
        total_cnt++; if (timed_out !== 1'b0) $display("FAIL b2b_timeout: got %b want 0", timed_out); else pass_cnt++;
        total_cnt++; if (got_addr.size() != 16) $display("FAIL b2b_count: got %0d want 16", got_addr.size()); else pass_cnt++;
        for (int i = 0; i < 16 && i < got_addr.size(); i++) begin
            ed = (exp_addr[i] < 8) ? (A_TAG | 64'(exp_addr[i])) : (B_TAG | 64'(exp_addr[i] - 8));
            total_cnt++;
            if (got_addr[i] !== 5'(exp_addr[i]) || got_data[i] !== ed)
                $display("FAIL b2b_write%0d: got addr %0d data %h want addr %0d data %h", i, got_addr[i], got_data[i], exp_addr[i], ed);
            else pass_cnt++;
        end
        if (got_cyc.size() > 0) begin
            total_cnt++; if (got_cyc[0] != 2) $display("FAIL b2b_first_cycle: got %0d want 2", got_cyc[0]); else pass_cnt++;
            total_cnt++;
            if (got_cyc[got_cyc.size()-1] - got_cyc[0] + 1 != 16)
                $display("FAIL b2b_throughput: got span %0d want 16", got_cyc[got_cyc.size()-1] - got_cyc[0] + 1);
            else pass_cnt++;
        end
        total_cnt++; if (rdy_b_hist[6] !== 1'b0) $display("FAIL b2b_b_ready_full: got %b want 0", rdy_b_hist[6]); else pass_cnt++;
        total_cnt++; if (idle !== 1'b1) $display("FAIL b2b_idle_end: got %b want 1", idle); else pass_cnt++;
    endtask

    task automatic test_b_backpressure();
        int exp_addr[14] = '{20, 8, 21, 9, 22, 10, 23, 11, 24, 12, 25, 13, 26, 27};
        logic [63:0] ed;
        do_reset();
        load_streams(8, 20, 6, 8);
        run_streams();
        total_cnt++; if (timed_out !== 1'b0) $display("FAIL bp_timeout: got %b want 0", timed_out); else pass_cnt++;
        total_cnt++; if (rdy_b_hist[6] !== 1'b0) $display("FAIL bp_b_ready_at4: got %b want 0", rdy_b_hist[6]); else pass_cnt++;
        total_cnt++; if (rdy_a_hist[6] !== 1'b1) $display("FAIL bp_a_ready_at3: got %b want 1", rdy_a_hist[6]); else pass_cnt++;
        total_cnt++; if (got_addr.size() != 14) $display("FAIL bp_count: got %0d want 14", got_addr.size()); else pass_cnt++;
        for (int i = 0; i < 14 && i < got_addr.size(); i++) begin
            ed = (exp_addr[i] >= 20) ? (A_TAG | 64'(exp_addr[i] - 20)) : (B_TAG | 64'(exp_addr[i] - 8));
            total_cnt++;
            if (got_addr[i] !== 5'(exp_addr[i]) || got_data[i] !== ed)
                $display("FAIL bp_write%0d: got addr %0d data %h want addr %0d data %h", i, got_addr[i], got_data[i], exp_addr[i], ed);
            else pass_cnt++;
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        load_streams(8, 0, 8, 8);
        run_streams();
        total_cnt++; if (timed_out !== 1'b0) $display("FAIL full_timeout: got %b want 0", timed_out); else pass_cnt++;
        total_cnt++; if (rdy_a_hist[7] !== 1'b0) $display("FAIL full_a_ready_e7: got %b want 0", rdy_a_hist[7]); else pass_cnt++;
        total_cnt++; if (rdy_a_hist[8] !== 1'b1) $display("FAIL full_a_ready_e8: got %b want 1", rdy_a_hist[8]); else pass_cnt++;
        total_cnt++; if (rdy_a_hist[9] !== 1'b0) $display("FAIL full_a_ready_e9: got %b want 0", rdy_a_hist[9]); else pass_cnt++;
        total_cnt++; if (got_addr.size() != 16) $display("FAIL full_no_dup: got %0d writes want 16", got_addr.size()); else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        int seen;
        do_reset();
        a_valid = 1'b1; a_addr = 5'd1; a_data = 64'h11;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 64'h22;
        @(posedge Clk); #1;
        a_addr = 5'd3; a_data = 64'h33;
        b_addr = 5'd4; b_data = 64'h44;
        @(posedge Clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        total_cnt++; if (wr_En !== 1'b1) $display("FAIL rst_pre_wr_en: got %b want 1", wr_En); else pass_cnt++;
        #3 Rst = 1'b1;
        #1;
        total_cnt++; if (wr_En !== 1'b0) $display("FAIL rst_async_wr_en: got %b want 0", wr_En); else pass_cnt++;
        total_cnt++; if (idle !== 1'b1) $display("FAIL rst_async_idle: got %b want 1", idle); else pass_cnt++;
        #2 Rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge Clk); #1;
            if (wr_En) seen++;
        end
        total_cnt++; if (seen != 0) $display("FAIL rst_stale_writes: got %0d want 0", seen); else pass_cnt++;
        total_cnt++; if (idle !== 1'b1) $display("FAIL rst_idle_after: got %b want 1", idle); else pass_cnt++;
        total_cnt++; if (a_ready !== 1'b1 || b_ready !== 1'b1)
            $display("FAIL rst_ready_after: got a=%b b=%b want 1 1", a_ready, b_ready); else pass_cnt++;
    endtask

`ifdef FP_WB_BUSY_EN
    task automatic test_busy_mask();
        do_reset();
        a_valid = 1'b1; a_addr = 5'd5;  a_data = 64'h55;
        b_valid = 1'b1; b_addr = 5'd17; b_data = 64'h77;
        @(posedge Clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        total_cnt++; if (busy_mask !== 32'h0002_0020) $display("FAIL busy_queued: got %h want 00020020", busy_mask); else pass_cnt++;
        @(posedge Clk); #1;  // A writing, B still queued
        total_cnt++; if (busy_mask !== 32'h0002_0020) $display("FAIL busy_a_write: got %h want 00020020", busy_mask); else pass_cnt++;
        @(posedge Clk); #1;  // B writing
        total_cnt++; if (busy_mask !== 32'h0002_0000) $display("FAIL busy_b_write: got %h want 00020000", busy_mask); else pass_cnt++;
        @(posedge Clk); #1;
        total_cnt++; if (busy_mask !== 32'h0000_0000) $display("FAIL busy_clear: got %h want 00000000", busy_mask); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_latency();
        test_back_to_back();
        test_b_backpressure();
        test_full_push_pop();
        test_reset_mid_op();
`ifdef FP_WB_BUSY_EN
        test_busy_mask();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
